// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch controller.
//   fetch_state_t : fetch FSM encoding (IDLE, REQ, WAIT)
//   redir_src_t   : which next-PC source won arbitration
//   RESET_PC_DEF, EXC_VECTOR_DEF, PC_STEP : default addresses and sequential step
//   redir_src()   : fixed-priority pick, jr > jump > branch > sequential
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        SRC_SEQ  = 2'd0,
        SRC_BR   = 2'd1,
        SRC_JUMP = 2'd2,
        SRC_JR   = 2'd3
    } redir_src_t;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] PC_STEP        = 32'd4;

    function automatic redir_src_t redir_src(input logic jr, input logic jump, input logic br_taken);
        if (jr)       return SRC_JR;
        if (jump)     return SRC_JUMP;
        if (br_taken) return SRC_BR;
        return SRC_SEQ;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_fetch_buf.sv
// One-entry valid/ready holding buffer between fetch and decode.
//   clk, rst_n            : clock, async active-low reset
//   push, push_instr/pc   : load a fetched word and its address
//   pop                   : decode consumed the current entry
//   flush                 : discard the entry (wins over push and pop)
//   valid, instr, pc      : buffered entry presented to decode
// The entry contents only change on push, so instr/pc are stable while
// valid is held without a pop.
module pc_fetch_ctrl_fetch_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic        pop,
    input  logic        flush,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (push) begin
                valid <= 1'b1;
                instr <= push_instr;
                pc    <= push_pc;
            end else if (pop) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC owner and imem sequencer with a single outstanding request.
//   clk, rst_n                          : clock, async active-low reset
//   br_taken/br_tgt, jump/j_tgt, jr/jr_tgt : redirect requests (jr > jump > branch)
//   imem_req/imem_addr/imem_gnt         : request channel, addr held until granted
//   imem_rvalid/imem_rdata              : response channel
//   if_valid/if_instr/if_pc, id_ready   : buffered instruction to decode
//   exc_misalign/exc_badaddr            : misaligned-redirect report
// Build option: PC_ALIGN_CHK_EN redirects misaligned targets to EXC_VECTOR and
// reports them; without it target[1:0] is cleared and the report is tied off.
//
// state | meaning
// IDLE  | first cycle after reset, no request
// REQ   | request pc_q when the buffer has room; wait for grant
// WAIT  | granted, waiting for rvalid; kill_q marks a stale response
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_taken,
    input  logic [31:0] br_tgt,
    input  logic        jump,
    input  logic [31:0] j_tgt,
    input  logic        jr,
    input  logic [31:0] jr_tgt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        exc_misalign,
    output logic [31:0] exc_badaddr
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         kill_q, kill_d;
    redir_src_t   src;
    logic         redirect;
    logic [31:0]  target_raw, target, redir_pc;
    logic         misalign;
    logic         push, pop;

    always_comb begin
        src        = redir_src(jr, jump, br_taken);
        redirect   = (src != SRC_SEQ);
        target_raw = br_tgt;
        case (src)
            SRC_JR:   target_raw = jr_tgt;
            SRC_JUMP: target_raw = j_tgt;
            default:  target_raw = br_tgt;
        endcase
    end

`ifdef PC_ALIGN_CHK_EN
    assign misalign = redirect && (target_raw[1:0] != 2'b00);
    assign target   = target_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_misalign <= 1'b0;
            exc_badaddr  <= '0;
        end else begin
            exc_misalign <= misalign;
            if (misalign) exc_badaddr <= target_raw;
        end
    end
`else
    assign misalign     = 1'b0;
    assign target       = target_raw & ~32'd3;
    assign exc_misalign = 1'b0;
    assign exc_badaddr  = '0;
`endif

    assign redir_pc = misalign ? EXC_VECTOR : target;
    assign pop      = if_valid && id_ready;

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        pc_d     = pc_q;
        push     = 1'b0;
        imem_req = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // Room is guaranteed for the response: a request only goes out
                // when the buffer is empty or being emptied this cycle.
                if (!if_valid || pop) begin
                    imem_req = 1'b1;
                    if (imem_gnt) state_d = WAIT;
                    if (redirect) kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                    if (kill_q || redirect) kill_d = 1'b0;
                    else                    push   = 1'b1;
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect)  pc_d = redir_pc;
        else if (push) pc_d = pc_q + PC_STEP;
        // An ungranted request keeps its address even across a redirect;
        // otherwise the address register simply follows the PC.
        addr_d = (imem_req && !imem_gnt) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            kill_q  <= kill_d;
        end
    end

    assign imem_addr = addr_q;

    pc_fetch_ctrl_fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (pc_q),
        .pop        (pop),
        .flush      (redirect),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_taken, jump, jr;
    logic [31:0] br_tgt, j_tgt, jr_tgt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        id_ready;
    logic        exc_misalign;
    logic [31:0] exc_badaddr;

    int          total = 0;
    int          bad = 0;
    logic        gnt_en = 1'b1;
    int          rlat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pa = '0;
    logic [31:0] exp_req = 32'h0000_3000;
    logic [31:0] exp_pop = 32'h0000_3000;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_taken     (br_taken),
        .br_tgt       (br_tgt),
        .jump         (jump),
        .j_tgt        (j_tgt),
        .jr           (jr),
        .jr_tgt       (jr_tgt),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .exc_misalign (exc_misalign),
        .exc_badaddr  (exc_badaddr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Let combinational outputs settle, then grant the request this cycle.
    task automatic settle();
        #1;
        imem_gnt = gnt_en && imem_req;
        #1;
    endtask

    // Advance one clock; the memory model returns data rlat cycles after grant.
    task automatic step();
        logic        g;
        logic [31:0] ga;
        g  = imem_gnt;
        ga = imem_addr;
        @(posedge clk);
        #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (g) begin
            pend = 1'b1;
            cnt  = rlat;
            pa   = ga;
        end
        if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pa);
                pend        = 1'b0;
            end
        end
    endtask

    task automatic clear_redirects();
        jr = 1'b0;
        jump = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_redirects();
        br_tgt = '0; j_tgt = '0; jr_tgt = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        id_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 7;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        if (imem_addr !== 32'h0000_3000) begin bad++; $display("FAIL rst_addr got=%h exp=00003000", imem_addr); end
        if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
        if (if_instr !== 32'h0) begin bad++; $display("FAIL rst_if_instr got=%h exp=0", if_instr); end
        if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
        if (exc_misalign !== 1'b0) begin bad++; $display("FAIL rst_exc got=%b exp=0", exc_misalign); end
        if (exc_badaddr !== 32'h0) begin bad++; $display("FAIL rst_badaddr got=%h exp=0", exc_badaddr); end
        rst_n = 1'b1;
        settle();
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        step();
        settle();
        total += 2;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
        if (imem_addr !== 32'h0000_3000) begin bad++; $display("FAIL first_addr got=%h exp=00003000", imem_addr); end
    endtask

    task automatic test_sequential();
        int pops = 0;
        for (int c = 0; c < 40 && pops < 3; c++) begin
            settle();
            if (imem_gnt) begin
                total++;
                if (imem_addr !== exp_req) begin bad++; $display("FAIL seq_req got=%h exp=%h", imem_addr, exp_req); end
                exp_req += 32'd4;
            end
            if (if_valid && id_ready) begin
                total++;
                if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin
                    bad++; $display("FAIL seq_pop pc got=%h exp=%h instr got=%h exp=%h", if_pc, exp_pop, if_instr, mem_word(exp_pop));
                end
                exp_pop += 32'd4;
                pops++;
            end
            step();
        end
        total++;
        if (pops != 3) begin bad++; $display("FAIL seq_timeout pops got=%0d exp=3", pops); end
    endtask

    task automatic test_stall();
        logic seen = 1'b0;
        int   pops = 0;
        id_ready = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            settle();
            if (imem_gnt) begin
                total++;
                if (imem_addr !== exp_req) begin bad++; $display("FAIL stall_req got=%h exp=%h", imem_addr, exp_req); end
                exp_req += 32'd4;
            end
            if (if_valid) seen = 1'b1;
            else step();
        end
        total++;
        if (!seen) begin bad++; $display("FAIL stall_timeout if_valid got=0 exp=1"); end
        for (int c = 0; c < 5; c++) begin
            settle();
            total += 3;
            if (if_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", if_valid); end
            if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin
                bad++; $display("FAIL stall_hold pc got=%h exp=%h instr got=%h exp=%h", if_pc, exp_pop, if_instr, mem_word(exp_pop));
            end
            if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_noreq got=%b exp=0", imem_req); end
            step();
        end
        id_ready = 1'b1;
        for (int c = 0; c < 20 && pops < 2; c++) begin
            settle();
            if (imem_gnt) begin
                total++;
                if (imem_addr !== exp_req) begin bad++; $display("FAIL resume_req got=%h exp=%h", imem_addr, exp_req); end
                exp_req += 32'd4;
            end
            if (if_valid && id_ready) begin
                total++;
                if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin
                    bad++; $display("FAIL resume_pop pc got=%h exp=%h", if_pc, exp_pop);
                end
                exp_pop += 32'd4;
                pops++;
            end
            step();
        end
        total++;
        if (pops != 2) begin bad++; $display("FAIL resume_timeout pops got=%0d exp=2", pops); end
    endtask

    task automatic test_jr_in_wait();
        logic got = 1'b0;
        int   pops = 0;
        rlat = 2;
        for (int c = 0; c < 20 && !got; c++) begin
            settle();
            if (imem_gnt) begin
                total++;
                if (imem_addr !== exp_req) begin bad++; $display("FAIL jrw_req got=%h exp=%h", imem_addr, exp_req); end
                exp_req += 32'd4;
                got = 1'b1;
            end
            if (if_valid && id_ready) begin
                total++;
                if (if_pc !== exp_pop) begin bad++; $display("FAIL jrw_pop got=%h exp=%h", if_pc, exp_pop); end
                exp_pop += 32'd4;
            end
            step();
        end
        total++;
        if (!got) begin bad++; $display("FAIL jrw_timeout grant got=0 exp=1"); end
        jr = 1'b1; jr_tgt = 32'h0000_5000;
        settle();
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL jrw_wait_req got=%b exp=0", imem_req); end
        if (if_valid && id_ready) begin
            total++;
            if (if_pc !== exp_pop) begin bad++; $display("FAIL jrw_pop2 got=%h exp=%h", if_pc, exp_pop); end
        end
        step();
        clear_redirects();
        settle();
        total += 2;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL jrw_drop_req got=%b exp=0", imem_req); end
        if (if_valid !== 1'b0) begin bad++; $display("FAIL jrw_flush got=%b exp=0", if_valid); end
        step();
        settle();
        total += 2;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL jrw_tgt_req got=%b exp=1", imem_req); end
        if (imem_addr !== 32'h0000_5000) begin bad++; $display("FAIL jrw_tgt_addr got=%h exp=00005000", imem_addr); end
        exp_req = 32'h0000_5000;
        exp_pop = 32'h0000_5000;
        for (int c = 0; c < 20 && pops < 2; c++) begin
            settle();
            if (imem_gnt) begin
                total++;
                if (imem_addr !== exp_req) begin bad++; $display("FAIL jrw_seq_req got=%h exp=%h", imem_addr, exp_req); end
                exp_req += 32'd4;
            end
            if (if_valid && id_ready) begin
                total++;
                if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin
                    bad++; $display("FAIL jrw_seq_pop pc got=%h exp=%h", if_pc, exp_pop);
                end
                exp_pop += 32'd4;
                pops++;
            end
            step();
        end
        total++;
        if (pops != 2) begin bad++; $display("FAIL jrw_seq_timeout pops got=%0d exp=2", pops); end
        rlat = 1;
    endtask

    task automatic test_priority();
        logic got = 1'b0;
        int   pops = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            settle();
            if (if_valid && id_ready) begin
                total++;
                if (if_pc !== exp_pop) begin bad++; $display("FAIL pri_pop got=%h exp=%h", if_pc, exp_pop); end
                exp_pop += 32'd4;
            end
            if (imem_gnt) got = 1'b1;
            step();
        end
        total++;
        if (!got) begin bad++; $display("FAIL pri_timeout grant got=0 exp=1"); end
        jr = 1'b1; jump = 1'b1; jr_tgt = 32'h0000_6000; j_tgt = 32'h0000_7000;
        settle();
        if (if_valid && id_ready) begin
            total++;
            if (if_pc !== exp_pop) begin bad++; $display("FAIL pri_pop2 got=%h exp=%h", if_pc, exp_pop); end
        end
        step();
        clear_redirects();
        settle();
        total += 3;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL pri_jr_req got=%b exp=1", imem_req); end
        if (imem_addr !== 32'h0000_6000) begin bad++; $display("FAIL pri_jr_addr got=%h exp=00006000", imem_addr); end
        if (if_valid !== 1'b0) begin bad++; $display("FAIL pri_flush got=%b exp=0", if_valid); end
        step();
        jump = 1'b1; j_tgt = 32'h0000_7000; br_taken = 1'b1; br_tgt = 32'h0000_8000;
        settle();
        step();
        clear_redirects();
        settle();
        total += 2;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL pri_j_req got=%b exp=1", imem_req); end
        if (imem_addr !== 32'h0000_7000) begin bad++; $display("FAIL pri_j_addr got=%h exp=00007000", imem_addr); end
        exp_req = 32'h0000_7000;
        exp_pop = 32'h0000_7000;
        for (int c = 0; c < 20 && pops < 2; c++) begin
            settle();
            if (imem_gnt) begin
                total++;
                if (imem_addr !== exp_req) begin bad++; $display("FAIL pri_seq_req got=%h exp=%h", imem_addr, exp_req); end
                exp_req += 32'd4;
            end
            if (if_valid && id_ready) begin
                total++;
                if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin
                    bad++; $display("FAIL pri_seq_pop pc got=%h exp=%h", if_pc, exp_pop);
                end
                exp_pop += 32'd4;
                pops++;
            end
            step();
        end
        total++;
        if (pops != 2) begin bad++; $display("FAIL pri_seq_timeout pops got=%0d exp=2", pops); end
    endtask

    task automatic test_redirect_no_gnt();
        logic        seen = 1'b0;
        logic [31:0] held;
        int          pops = 0;
        gnt_en = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            settle();
            if (if_valid && id_ready) begin
                total++;
                if (if_pc !== exp_pop) begin bad++; $display("FAIL hold_pop got=%h exp=%h", if_pc, exp_pop); end
                exp_pop += 32'd4;
            end
            if (imem_req) seen = 1'b1;
            else step();
        end
        total += 2;
        if (!seen) begin bad++; $display("FAIL hold_timeout req got=0 exp=1"); end
        if (imem_addr !== exp_req) begin bad++; $display("FAIL hold_addr0 got=%h exp=%h", imem_addr, exp_req); end
        held = exp_req;
        br_taken = 1'b1; br_tgt = 32'h0000_9000;
        settle();
        step();
        clear_redirects();
        for (int c = 0; c < 2; c++) begin
            settle();
            total += 2;
            if (imem_req !== 1'b1) begin bad++; $display("FAIL hold_req got=%b exp=1", imem_req); end
            if (imem_addr !== held) begin bad++; $display("FAIL hold_addr got=%h exp=%h", imem_addr, held); end
            step();
        end
        gnt_en = 1'b1;
        settle();
        total += 2;
        if (imem_gnt !== 1'b1) begin bad++; $display("FAIL hold_gnt req got=%b exp=1", imem_gnt); end
        if (imem_addr !== held) begin bad++; $display("FAIL hold_gnt_addr got=%h exp=%h", imem_addr, held); end
        step();
        settle();
        total += 2;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_drop_req got=%b exp=0", imem_req); end
        if (if_valid !== 1'b0) begin bad++; $display("FAIL hold_drop_valid got=%b exp=0", if_valid); end
        step();
        settle();
        total += 2;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL hold_tgt_req got=%b exp=1", imem_req); end
        if (imem_addr !== 32'h0000_9000) begin bad++; $display("FAIL hold_tgt_addr got=%h exp=00009000", imem_addr); end
        exp_req = 32'h0000_9000;
        exp_pop = 32'h0000_9000;
        for (int c = 0; c < 20 && pops < 2; c++) begin
            settle();
            if (imem_gnt) begin
                total++;
                if (imem_addr !== exp_req) begin bad++; $display("FAIL hold_seq_req got=%h exp=%h", imem_addr, exp_req); end
                exp_req += 32'd4;
            end
            if (if_valid && id_ready) begin
                total++;
                if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin
                    bad++; $display("FAIL hold_seq_pop pc got=%h exp=%h", if_pc, exp_pop);
                end
                exp_pop += 32'd4;
                pops++;
            end
            step();
        end
        total++;
        if (pops != 2) begin bad++; $display("FAIL hold_seq_timeout pops got=%0d exp=2", pops); end
    endtask

    task automatic test_wrap_and_align();
        logic        got;
        int          pops;
        logic [31:0] exp_tgt;
        logic        exp_exc;
        logic [31:0] exp_bad;
        // Sequential wrap through the top of the address space.
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            settle();
            if (if_valid && id_ready) exp_pop += 32'd4;
            if (imem_gnt) got = 1'b1;
            step();
        end
        br_taken = 1'b1; br_tgt = 32'hFFFF_FFF8;
        settle();
        step();
        clear_redirects();
        exp_req = 32'hFFFF_FFF8;
        exp_pop = 32'hFFFF_FFF8;
        pops = 0;
        for (int c = 0; c < 30 && pops < 3; c++) begin
            settle();
            if (imem_gnt) begin
                total++;
                if (imem_addr !== exp_req) begin bad++; $display("FAIL wrap_req got=%h exp=%h", imem_addr, exp_req); end
                exp_req += 32'd4;
            end
            if (if_valid && id_ready) begin
                total++;
                if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin
                    bad++; $display("FAIL wrap_pop pc got=%h exp=%h", if_pc, exp_pop);
                end
                exp_pop += 32'd4;
                pops++;
            end
            step();
        end
        total++;
        if (pops != 3) begin bad++; $display("FAIL wrap_timeout pops got=%0d exp=3", pops); end
        // Misaligned branch target.
`ifdef PC_ALIGN_CHK_EN
        exp_tgt = 32'h0000_4180; exp_exc = 1'b1; exp_bad = 32'h0000_3002;
`else
        exp_tgt = 32'h0000_3000; exp_exc = 1'b0; exp_bad = 32'h0000_0000;
`endif
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            settle();
            if (imem_gnt) got = 1'b1;
            step();
        end
        br_taken = 1'b1; br_tgt = 32'h0000_3002;
        settle();
        total++;
        if (exc_misalign !== 1'b0) begin bad++; $display("FAIL align_pre got=%b exp=0", exc_misalign); end
        step();
        clear_redirects();
        settle();
        total += 4;
        if (exc_misalign !== exp_exc) begin bad++; $display("FAIL align_pulse got=%b exp=%b", exc_misalign, exp_exc); end
        if (exc_badaddr !== exp_bad) begin bad++; $display("FAIL align_badaddr got=%h exp=%h", exc_badaddr, exp_bad); end
        if (imem_req !== 1'b1) begin bad++; $display("FAIL align_req got=%b exp=1", imem_req); end
        if (imem_addr !== exp_tgt) begin bad++; $display("FAIL align_addr got=%h exp=%h", imem_addr, exp_tgt); end
        step();
        settle();
        total += 2;
        if (exc_misalign !== 1'b0) begin bad++; $display("FAIL align_once got=%b exp=0", exc_misalign); end
        if (exc_badaddr !== exp_bad) begin bad++; $display("FAIL align_held got=%h exp=%h", exc_badaddr, exp_bad); end
        exp_req = exp_tgt + 32'd4;
        exp_pop = exp_tgt;
        pops = 0;
        for (int c = 0; c < 20 && pops < 2; c++) begin
            if (c != 0) settle();
            if (c != 0 && imem_gnt) begin
                total++;
                if (imem_addr !== exp_req) begin bad++; $display("FAIL align_seq_req got=%h exp=%h", imem_addr, exp_req); end
                exp_req += 32'd4;
            end
            if (if_valid && id_ready) begin
                total++;
                if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin
                    bad++; $display("FAIL align_seq_pop pc got=%h exp=%h", if_pc, exp_pop);
                end
                exp_pop += 32'd4;
                pops++;
            end
            step();
        end
        total++;
        if (pops != 2) begin bad++; $display("FAIL align_seq_timeout pops got=%0d exp=2", pops); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jr_in_wait();
        test_priority();
        test_redirect_no_gnt();
        test_wrap_and_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
